// File: rtl/regfile_bus_ctrl.sv
// Register-file side of the nibble bus: fetches a register index, drives that
// register toward the ALU core, and writes the core's result and carry back.
module regfile_bus_ctrl #(
  parameter int DW   = 4,
  parameter int AW   = 4,
  parameter int HOLD = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    bus_req,
  input  logic [DW-1:0] bus_in,
  input  logic          core_done,
  input  logic          core_carry,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          core_oe_n,
  input  logic [AW-1:0] instr_data,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          carry_flag,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(HOLD + 1);
  localparam logic [3:0] REQ_FETCH = 4'b0011;
  localparam logic [3:0] REQ_READ  = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READ  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_regs [NREG];
  logic [AW-1:0] r_idx;
  logic [3:0]    r_req_q;
  logic          r_done_q;
  logic [CW-1:0] r_cnt;
  logic          w_new_req;
  logic          w_done_rise;
  logic          w_hold_done;

  // Requests act only on a change of code; completion acts only on a 0->1 edge.
  assign w_new_req   = (bus_req != r_req_q);
  assign w_done_rise = core_done & ~r_done_q;
  assign w_hold_done = (r_cnt == CW'(HOLD));
  assign dbg_data    = r_regs[dbg_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; in IDLE writeback beats read beats fetch, losers are dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_done_rise) begin
          w_next = S_WB;
        end else if (w_new_req && (bus_req == REQ_READ)) begin
          w_next = S_READ;
        end else if (w_new_req && (bus_req == REQ_FETCH)) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: begin
        if (instr_valid) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_READ: begin
        if (w_hold_done) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_READ;
        end
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Fetch handshake is offered for as long as the FSM sits in FETCH
  always_comb begin
    if (r_state == S_FETCH) begin
      instr_ready = 1'b1;
    end else begin
      instr_ready = 1'b0;
    end
  end

  // Datapath: edge history, index capture, read window and writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_idx      <= '0;
      r_req_q    <= 4'b0000;
      r_done_q   <= 1'b0;
      r_cnt      <= '0;
      bus_out    <= '0;
      bus_oe     <= 1'b0;
      core_oe_n  <= 1'b1;
      carry_flag <= 1'b0;
    end else begin
      r_req_q  <= bus_req;
      r_done_q <= core_done;
      case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_idx <= instr_data;
          end
        end
        S_READ: begin
          // bus_out keeps the last value after the window so the core can still latch it
          if (w_hold_done) begin
            bus_oe    <= 1'b0;
            core_oe_n <= 1'b0;
            r_cnt     <= '0;
          end else begin
            bus_oe <= 1'b1;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == '0) begin
              bus_out <= r_regs[r_idx];
            end
          end
        end
        S_WB: begin
          r_regs[r_idx] <= bus_in;
          carry_flag    <= core_carry;
          core_oe_n     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bus_ctrl.sv
// Randomised and directed bench for regfile_bus_ctrl against a transaction-level
// model of the request/fetch/read/writeback rules.
module tb_regfile_bus_ctrl;

  localparam int DW   = 4;
  localparam int AW   = 4;
  localparam int HOLD = 2;
  localparam int K_NONE = 0, K_FETCH = 1, K_READ = 2, K_WB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    bus_req;
  logic [DW-1:0] bus_in;
  logic          core_done;
  logic          core_carry;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          core_oe_n;
  logic [AW-1:0] instr_data;
  logic          instr_valid;
  logic          instr_ready;
  logic          carry_flag;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  regfile_bus_ctrl #(.DW(DW), .AW(AW), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_in(bus_in),
    .core_done(core_done), .core_carry(core_carry), .bus_out(bus_out),
    .bus_oe(bus_oe), .core_oe_n(core_oe_n), .instr_data(instr_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .carry_flag(carry_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks which transaction is in flight and how long it has run
  int            m_kind;
  int            m_age;
  logic [DW-1:0] m_regs [1<<AW];
  logic [AW-1:0] m_idx;
  logic [3:0]    m_rq;
  logic          m_dn;
  logic [DW-1:0] m_out;
  logic          m_oe;
  logic          m_coen;
  logic          m_carry;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind <= K_NONE; m_age <= 0; m_idx <= '0; m_rq <= 4'd0; m_dn <= 1'b0;
      m_out <= '0; m_oe <= 1'b0; m_coen <= 1'b1; m_carry <= 1'b0;
      for (int i = 0; i < (1<<AW); i++) m_regs[i] <= '0;
    end else begin
      m_rq <= bus_req;
      m_dn <= core_done;
      case (m_kind)
        K_NONE: begin
          if (core_done && !m_dn) m_kind <= K_WB;
          else if (bus_req != m_rq && bus_req == 4'd1) begin m_kind <= K_READ; m_age <= 0; end
          else if (bus_req != m_rq && bus_req == 4'd3) m_kind <= K_FETCH;
        end
        K_FETCH: if (instr_valid) begin m_idx <= instr_data; m_kind <= K_NONE; end
        K_READ: begin
          if (m_age < HOLD) begin
            m_oe <= 1'b1;
            if (m_age == 0) m_out <= m_regs[m_idx];
            m_age <= m_age + 1;
          end else begin
            m_oe <= 1'b0; m_coen <= 1'b0; m_kind <= K_NONE;
          end
        end
        default: begin
          m_regs[m_idx] <= bus_in; m_carry <= core_carry; m_coen <= 1'b1; m_kind <= K_NONE;
        end
      endcase
    end
  end

  // Per-cycle compare plus activity counters used by the directed checks
  int oe_cnt = 0, rdy_cnt = 0, hs_cnt = 0;
  int oe_val = 0;
  always @(negedge clk) begin
    chk("bus_out",     int'(bus_out),     int'(m_out));
    chk("bus_oe",      int'(bus_oe),      int'(m_oe));
    chk("core_oe_n",   int'(core_oe_n),   int'(m_coen));
    chk("instr_ready", int'(instr_ready), (m_kind == K_FETCH) ? 1 : 0);
    chk("carry_flag",  int'(carry_flag),  int'(m_carry));
    chk("dbg_data",    int'(dbg_data),    int'(m_regs[dbg_addr]));
    if (bus_oe) begin oe_cnt++; oe_val = int'(bus_out); end
    if (instr_ready) rdy_cnt++;
    if (instr_ready && instr_valid) hs_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  int oe0, rdy0, hs0, r;

  initial begin
    rst_n = 1'b0; bus_req = 4'd0; bus_in = '0; core_done = 1'b0; core_carry = 1'b0;
    instr_data = '0; instr_valid = 1'b0; dbg_addr = '0;
    step(3);
    rst_n = 1'b1;
    chk("rst_bus_oe", int'(bus_oe), 0);
    chk("rst_core_oe_n", int'(core_oe_n), 1);
    chk("rst_carry", int'(carry_flag), 0);
    step(2);

    // Fetch with a 5-cycle stall, then index 7
    rdy0 = rdy_cnt; hs0 = hs_cnt;
    bus_req = 4'b0011;
    step(6);
    instr_valid = 1'b1; instr_data = 4'h7;
    step(1);
    instr_valid = 1'b0; instr_data = 4'h0;
    step(3);
    chk("fetch_ready_cycles", rdy_cnt - rdy0, 6);
    chk("fetch_handshakes", hs_cnt - hs0, 1);

    // Seed reg7 = 5 through a writeback, then read it
    dbg_addr = 4'h7; bus_in = 4'h5; core_done = 1'b1;
    step(3);
    core_done = 1'b0;
    step(1);
    chk("seed_reg7", int'(dbg_data), 5);
    oe0 = oe_cnt;
    bus_req = 4'b0001;
    step(6);
    chk("read_oe_cycles", oe_cnt - oe0, HOLD);
    chk("read_value", oe_val, 5);
    chk("read_core_oe_n", int'(core_oe_n), 0);

    // Writeback 0xC with carry; a held done must not write again
    bus_in = 4'hC; core_carry = 1'b1; core_done = 1'b1;
    step(4);
    chk("wb_reg7", int'(dbg_data), 12);
    chk("wb_carry", int'(carry_flag), 1);
    chk("wb_core_oe_n", int'(core_oe_n), 1);
    bus_in = 4'h3; core_carry = 1'b0;
    step(5);
    chk("wb_held_no_rewrite", int'(dbg_data), 12);
    core_done = 1'b0;
    step(2);

    // Held read code for 10 cycles yields exactly one window
    bus_req = 4'd0;
    step(2);
    oe0 = oe_cnt;
    bus_req = 4'b0001;
    step(10);
    chk("held_req_oe_cycles", oe_cnt - oe0, HOLD);

    // Done edge and read edge together: writeback only
    bus_req = 4'd0;
    step(3);
    oe0 = oe_cnt;
    bus_in = 4'h9; core_done = 1'b1; bus_req = 4'b0001;
    step(6);
    chk("collision_no_oe", oe_cnt - oe0, 0);
    chk("collision_wb", int'(dbg_data), 9);
    core_done = 1'b0;
    bus_req = 4'd0;
    step(3);

    // Async reset in the middle of a read window
    bus_req = 4'b0001;
    step(2);
    chk("pre_reset_oe", int'(bus_oe), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_bus_oe", int'(bus_oe), 0);
    chk("reset_core_oe_n", int'(core_oe_n), 1);
    for (int a = 0; a < (1<<AW); a++) begin
      dbg_addr = a[AW-1:0];
      #1;
      chk("reset_dbg_zero", int'(dbg_data), 0);
    end
    bus_req = 4'd0;
    step(1);
    rst_n = 1'b1;
    step(2);

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r == 4 || r == 5) bus_req = 4'b0001;
      else if (r == 6 || r == 7) bus_req = 4'b0011;
      else if (r == 8) bus_req = 4'd0;
      else if (r == 9) bus_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) core_done = ~core_done;
      instr_valid = ($urandom_range(0, 2) == 0);
      instr_data  = 4'($urandom_range(0, 15));
      bus_in      = 4'($urandom_range(0, 15));
      core_carry  = 1'($urandom_range(0, 1));
      dbg_addr    = 4'($urandom_range(0, 15));
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
